// File: rtl/core_lsu_pkg.sv
// core_lsu_pkg: shared encodings for the load/store unit.
//   size_e  - access size (byte/half/word); encoding 3 is folded to word
//   err_e   - completion status reported on resp_err_o
//   state_e - transfer FSM states
package core_lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_BUS      = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } err_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Raw size field to access size; the illegal encoding 3 behaves as a word.
  function automatic size_e norm_size(input logic [1:0] sz);
    case (sz)
      2'd0:    return SZ_BYTE;
      2'd1:    return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input size_e sz, input logic [1:0] a);
    case (sz)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return a[0];
      default: return (a != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/core_lsu_align.sv
// core_lsu_align: combinational lane steering for the load/store unit.
//   size_i, addr_lo_i, signed_i - access description (byte offset in word)
//   wdata_i -> wdata_o, be_o     - store data replicated on all lanes + enables
//   rdata_i -> rdata_o           - load data shifted down and sign/zero extended
module core_lsu_align
  import core_lsu_pkg::*;
(
  input  size_e       size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        signed_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;

  assign shifted = rdata_i >> {addr_lo_i, 3'b000};

  always_comb begin
    be_o    = '1;
    wdata_o = wdata_i;
    rdata_o = shifted;
    case (size_i)
      SZ_BYTE: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{signed_i & shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        be_o    = 4'b0011 << addr_lo_i;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{signed_i & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        be_o    = '1;
        wdata_o = wdata_i;
        rdata_o = shifted;
      end
    endcase
  end

endmodule

// File: rtl/core_lsu.sv
// core_lsu: load/store unit between execute stage and peripheral bus.
//   req_*      - request from execute (valid, wr, addr, wdata, size, signed, rd)
//   flush_i    - abort the current request
//   hold_flag_o- stall pipeline while a transfer is outstanding
//   resp_*     - one-cycle completion (data, rd, write enable, error code)
//   bus_*      - req/ready/rvalid bus with word address and byte enables
module core_lsu
  import core_lsu_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  input  logic              req_wr_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_signed_i,
  input  logic [4:0]        req_rd_i,
  input  logic              flush_i,
  output logic              hold_flag_o,
  output logic              resp_valid_o,
  output logic [31:0]       resp_data_o,
  output logic [4:0]        resp_rd_o,
  output logic              resp_wr_en_o,
  output logic [1:0]        resp_err_o,
  output logic              bus_req_o,
  input  logic              bus_ready_i,
  output logic              bus_wr_en_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [31:0]       bus_wdata_o,
  output logic [3:0]        bus_be_o,
  input  logic              bus_rvalid_i,
  input  logic [31:0]       bus_rdata_i,
  input  logic              bus_err_i
);

  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  size_e             size_q, size_d;
  logic              signed_q, signed_d;
  logic [4:0]        rd_q, rd_d;
  err_e              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;

  logic        timeout_hit;
  logic [3:0]  be;
  logic [31:0] wdata_rep;
  logic [31:0] rdata_ext;
  logic        in_req, in_done;

  core_lsu_align u_align (
    .size_i    (size_q),
    .addr_lo_i (addr_q[1:0]),
    .signed_i  (signed_q),
    .wdata_i   (wdata_q),
    .rdata_i   (rdata_q),
    .be_o      (be),
    .wdata_o   (wdata_rep),
    .rdata_o   (rdata_ext)
  );

  // ">=" rather than "==" so a cycle that defers the timeout (flush taking
  // priority) still times out on the following cycle.
  assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q >= TO_LAST);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    size_d   = size_q;
    signed_d = signed_q;
    rd_d     = rd_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (req_valid_i && !flush_i) begin
          wr_d     = req_wr_i;
          addr_d   = req_addr_i;
          wdata_d  = req_wdata_i;
          size_d   = norm_size(req_size_i);
          signed_d = req_signed_i;
          rd_d     = req_rd_i;
          if (is_misaligned(norm_size(req_size_i), req_addr_i[1:0])) begin
            err_d   = ERR_MISALIGN;
            state_d = ST_DONE;
          end else begin
            err_d   = ERR_NONE;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (flush_i) begin
          // Accepted in the same cycle: a response is still owed by the bus.
          state_d = bus_ready_i ? ST_DRAIN : ST_IDLE;
        end else if (timeout_hit) begin
          err_d   = ERR_TIMEOUT;
          state_d = ST_DONE;
        end else if (bus_ready_i) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus_rvalid_i) begin
          if (flush_i) begin
            state_d = ST_IDLE;
          end else begin
            rdata_d = bus_rdata_i;
            if (bus_err_i) err_d = ERR_BUS;
            else           err_d = ERR_NONE;
            state_d = ST_DONE;
          end
        end else if (flush_i) begin
          state_d = ST_DRAIN;
        end else if (timeout_hit) begin
          err_d   = ERR_TIMEOUT;
          state_d = ST_DONE;
        end
      end
      ST_DRAIN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus_rvalid_i || timeout_hit) state_d = ST_IDLE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= SZ_BYTE;
      signed_q <= 1'b0;
      rd_q     <= '0;
      err_q    <= ERR_NONE;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      rd_q     <= rd_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  assign in_req  = (state_q == ST_REQ);
  assign in_done = (state_q == ST_DONE);

  assign bus_req_o   = in_req;
  assign bus_wr_en_o = in_req & wr_q;
  assign bus_addr_o  = in_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign bus_be_o    = in_req ? be : '0;
  assign bus_wdata_o = in_req ? wdata_rep : '0;

  assign resp_valid_o = in_done;
  assign resp_err_o   = in_done ? err_q : ERR_NONE;
  assign resp_rd_o    = in_done ? rd_q : '0;
  assign resp_wr_en_o = in_done & ~wr_q & (err_q == ERR_NONE);
  assign resp_data_o  = resp_wr_en_o ? rdata_ext : '0;

  assign hold_flag_o = ((state_q == ST_IDLE) & req_valid_i & ~flush_i)
                     | in_req | (state_q == ST_WAIT);

endmodule

// File: tb/tb_core_lsu.sv
// tb_core_lsu: scoreboard bench for core_lsu. The driver plays both the
// execute stage and the bus; each transaction's outcome is predicted from
// the bus timing chosen for it and queued; a monitor pops on resp_valid_o.
module tb_core_lsu;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i, req_wr_i, req_signed_i, flush_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic [1:0]  req_size_i;
  logic [4:0]  req_rd_i;
  logic        hold_flag_o, resp_valid_o, resp_wr_en_o;
  logic [31:0] resp_data_o;
  logic [4:0]  resp_rd_o;
  logic [1:0]  resp_err_o;
  logic        bus_req_o, bus_ready_i, bus_wr_en_o, bus_rvalid_i, bus_err_i;
  logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
  logic [3:0]  bus_be_o;

  core_lsu #(.ADDR_W(32), .TIMEOUT_CYC(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_wr_i(req_wr_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .req_size_i(req_size_i),
    .req_signed_i(req_signed_i), .req_rd_i(req_rd_i), .flush_i(flush_i),
    .hold_flag_o(hold_flag_o), .resp_valid_o(resp_valid_o),
    .resp_data_o(resp_data_o), .resp_rd_o(resp_rd_o),
    .resp_wr_en_o(resp_wr_en_o), .resp_err_o(resp_err_o),
    .bus_req_o(bus_req_o), .bus_ready_i(bus_ready_i),
    .bus_wr_en_o(bus_wr_en_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o),
    .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i),
    .bus_err_i(bus_err_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        wen;
    logic [1:0]  err;
  } resp_t;

  resp_t exp_q[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model pieces, written in terms of bytes and lanes.
  function automatic int unsigned nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rdata, input int unsigned a,
                                             input logic [1:0] sz, input logic sg);
    int unsigned n;
    logic [31:0] v, mask;
    n = nbytes(sz);
    v = rdata >> (8 * a);
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
    v = v & mask;
    if (sg && n < 4 && v[8 * n - 1]) v = v | ~mask;
    return v;
  endfunction

  task automatic model_lanes(input logic [31:0] wd, input int unsigned a, input logic [1:0] sz,
                             output logic [3:0] be, output logic [31:0] lanes);
    int unsigned n;
    n = nbytes(sz);
    for (int unsigned i = 0; i < 4; i++) begin
      be[i] = (i >= a) && (i < a + n);
      lanes[8 * i +: 8] = wd[8 * (i % n) +: 8];
    end
  endtask

  // Monitor: every response must match the oldest outstanding prediction.
  always @(negedge clk) begin
    resp_t e;
    if (!rst && resp_valid_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got err=%0d data=%h rd=%0d, expected no response",
                 resp_err_o, resp_data_o, resp_rd_o);
      end else begin
        e = exp_q.pop_front();
        check("resp_data", 64'(resp_data_o), 64'(e.data));
        check("resp_rd", 64'(resp_rd_o), 64'(e.rd));
        check("resp_wr_en", 64'(resp_wr_en_o), 64'(e.wen));
        check("resp_err", 64'(resp_err_o), 64'(e.err));
        check("hold_in_done", 64'(hold_flag_o), 64'd0);
      end
    end
  end

  // kind: 0 = no flush, 1 = flush in REQ at cycle f, 2 = flush in WAIT at cycle f.
  // r/v: cycle numbers (1 = first cycle after issue) of bus_ready_i / bus_rvalid_i; 0 = never.
  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [1:0] sz, input logic sg, input logic [4:0] rd,
                         input int unsigned kind, input int unsigned r, input int unsigned v,
                         input int unsigned f, input logic berr, input logic [31:0] rdata,
                         input logic fiss, input logic reissue);
    int unsigned a, last, reqc, hold_end;
    logic resp, exp_req, bus_bad, hold_bad;
    logic [3:0] ebe;
    logic [31:0] ewd;
    resp_t e;
    a = int'(addr[1:0]);
    last = 0; reqc = 0; hold_end = 0;
    resp = 1'b0; bus_bad = 1'b0; hold_bad = 1'b0;
    e.data = '0; e.rd = rd; e.wen = 1'b0; e.err = 2'd0;
    model_lanes(wd, a, sz, ebe, ewd);
    if (fiss) begin
      resp = 1'b0;
    end else if ((a % nbytes(sz)) != 0) begin
      resp = 1'b1;
      e.err = 2'd1;
    end else if (kind == 1) begin
      last = f; reqc = f; hold_end = f;
    end else if (kind == 2) begin
      last = (v < ((f + 1 > TO) ? f + 1 : TO)) ? v : ((f + 1 > TO) ? f + 1 : TO);
      reqc = r; hold_end = f;
    end else begin
      resp = 1'b1;
      if (r >= 1 && r <= TO - 1 && v <= TO) begin
        reqc = r; last = v;
        e.err = berr ? 2'd2 : 2'd0;
        e.wen = !wr && !berr;
        e.data = e.wen ? model_load(rdata, a, sz, sg) : 32'd0;
      end else begin
        reqc = (r >= 1 && r <= TO - 1) ? r : TO;
        last = TO;
        e.err = 2'd3;
      end
      hold_end = last;
    end

    @(negedge clk);
    req_valid_i = 1'b1; req_wr_i = wr; req_addr_i = addr; req_wdata_i = wd;
    req_size_i = sz; req_signed_i = sg; req_rd_i = rd; flush_i = fiss;
    if (resp) exp_q.push_back(e);
    #1;
    if (hold_flag_o !== !fiss) hold_bad = 1'b1;
    if (bus_req_o !== 1'b0) bus_bad = 1'b1;

    for (int unsigned n = 1; n <= last; n++) begin
      @(negedge clk);
      req_valid_i = 1'b0;
      flush_i = (kind != 0) && (n == f);
      bus_ready_i = (n == r);
      bus_rvalid_i = (n == v);
      bus_err_i = (n == v) && berr;
      bus_rdata_i = (n == v) ? rdata : $urandom;
      #1;
      exp_req = (n <= reqc);
      if (bus_req_o !== exp_req) bus_bad = 1'b1;
      if (exp_req && (bus_addr_o !== {addr[31:2], 2'b00} || bus_be_o !== ebe ||
                      bus_wdata_o !== ewd || bus_wr_en_o !== wr)) bus_bad = 1'b1;
      if (hold_flag_o !== (n <= hold_end)) hold_bad = 1'b1;
    end

    @(negedge clk);
    req_valid_i = 1'b0; flush_i = 1'b0; bus_ready_i = 1'b0;
    bus_rvalid_i = 1'b0; bus_err_i = 1'b0;
    if (resp && reissue) begin
      // A request presented during the completion cycle must be ignored;
      // a misaligned one would produce a visible extra response.
      req_valid_i = 1'b1; req_addr_i = 32'h0000_4001; req_size_i = 2'd2;
    end
    #1;
    if (bus_req_o !== 1'b0 || hold_flag_o !== 1'b0) bus_bad = 1'b1;
    check("bus_sequence", 64'(bus_bad), 64'd0);
    check("hold_sequence", 64'(hold_bad), 64'd0);

    @(negedge clk);
    req_valid_i = 1'b0;
    repeat ($urandom_range(0, 2)) begin
      bus_rvalid_i = 1'($urandom_range(0, 1));
      bus_rdata_i = $urandom;
      @(negedge clk);
    end
    bus_rvalid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] ad;
    logic [1:0] sz;
    int unsigned p, kr, kv, kf, kk;
    rst = 1'b1;
    req_valid_i = 0; req_wr_i = 0; req_addr_i = '0; req_wdata_i = '0; req_size_i = '0;
    req_signed_i = 0; req_rd_i = '0; flush_i = 0;
    bus_ready_i = 0; bus_rvalid_i = 0; bus_rdata_i = '0; bus_err_i = 0;
    repeat (3) @(negedge clk);
    check("reset_bus", 64'({bus_req_o, bus_wr_en_o, bus_be_o, bus_addr_o}), 64'd0);
    check("reset_wdata", 64'(bus_wdata_o), 64'd0);
    check("reset_resp", 64'({resp_valid_o, resp_wr_en_o, resp_err_o, resp_rd_o, hold_flag_o}), 64'd0);
    check("reset_data", 64'(resp_data_o), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    //     wr  addr          wdata         sz  sg rd  kind r   v       f  berr rdata         fiss reis
    run_txn(0, 32'h0000_1000, 32'h0,       2, 0, 5,  0,  1,  2,      0, 0, 32'hDEAD_BEEF, 0, 0);
    run_txn(0, 32'h0000_1003, 32'h0,       0, 1, 6,  0,  1,  2,      0, 0, 32'h8011_2233, 0, 0);
    run_txn(0, 32'h0000_1003, 32'h0,       0, 0, 6,  0,  1,  2,      0, 0, 32'h8011_2233, 0, 1);
    run_txn(1, 32'h0000_2002, 32'hABCD,    1, 0, 9,  0,  2,  4,      0, 0, 32'h0,         0, 0);
    run_txn(0, 32'h0000_3001, 32'h0,       2, 0, 3,  0,  1,  2,      0, 0, 32'h0,         0, 1);
    run_txn(0, 32'h0000_3004, 32'h0,       2, 0, 4,  0,  0,  0,      0, 0, 32'h0,         0, 0);
    run_txn(0, 32'h0000_3008, 32'h0,       2, 0, 4,  2,  1,  5,      2, 0, 32'h1234_5678, 0, 0);
    run_txn(0, 32'h0000_0040, 32'h0,       1, 1, 7,  0,  1,  2,      0, 0, 32'hF00D_8001, 0, 0);
    run_txn(0, 32'h0000_0044, 32'h0,       2, 0, 8,  1,  0,  0,      2, 0, 32'h0,         0, 0);
    run_txn(0, 32'h0000_0048, 32'h0,       2, 0, 8,  0,  1,  2,      0, 0, 32'h0,         1, 0);
    run_txn(0, 32'h0000_004C, 32'h0,       2, 0, 10, 0,  1,  3,      0, 1, 32'h5555_5555, 0, 0);
    run_txn(0, 32'h0000_0050, 32'h0,       2, 0, 11, 0,  2,  TO,     0, 0, 32'h0BAD_CAFE, 0, 0);
    run_txn(0, 32'h0000_0054, 32'h0,       2, 0, 12, 0,  2,  TO + 1, 0, 0, 32'h0,         0, 0);
    run_txn(1, 32'h0000_0058, 32'h77,      2, 0, 13, 0,  TO, TO + 1, 0, 0, 32'h0,         0, 0);
    run_txn(0, 32'h0000_005C, 32'h0,       3, 1, 14, 0,  1,  2,      0, 0, 32'h8765_4321, 0, 0);

    for (int i = 0; i < 60; i++) begin
      sz = 2'($urandom_range(0, 3));
      ad = $urandom;
      if ($urandom_range(0, 9) < 7) begin
        if (sz == 2'd1) ad[0] = 1'b0;
        else if (sz != 2'd0) ad[1:0] = 2'b00;
      end
      p = $urandom_range(0, 9);
      kk = 0; kr = 0; kv = 0; kf = 0;
      if (p <= 5) begin
        kr = $urandom_range(0, TO);
        kv = kr + $urandom_range(1, 4);
      end else if (p == 6) begin
        kk = 1; kf = $urandom_range(1, TO - 1);
      end else if (p <= 8) begin
        kk = 2; kr = $urandom_range(1, TO - 2);
        kf = $urandom_range(kr + 1, TO);
        kv = $urandom_range(kf + 1, kf + 4);
      end
      run_txn(1'($urandom_range(0, 1)), ad, $urandom, sz, 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 31)), kk, kr, kv, kf, ($urandom_range(0, 3) == 0),
              $urandom, (p == 9), 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset in the middle of a transfer.
    @(negedge clk);
    req_valid_i = 1'b1; req_wr_i = 1'b0; req_addr_i = 32'h0000_0100;
    req_size_i = 2'd2; flush_i = 1'b0;
    @(negedge clk);
    req_valid_i = 1'b0;
    #1 check("req_before_reset", 64'(bus_req_o), 64'd1);
    #2 rst = 1'b1;
    #1 check("async_reset_mid", 64'({bus_req_o, hold_flag_o, resp_valid_o}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_txn(0, 32'h0000_0200, 32'h0, 2, 0, 21, 0, 1, 2, 0, 0, 32'hCAFE_0001, 0, 0);

    repeat (4) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
